// File: rtl/fifo_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : fifo_write_arbiter
// Brief   : Round-robin write arbiter sharing one FIFO write port between
//           NUM_REQ producers, with a bounded burst length per grant and
//           backpressure from the FIFO full flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter #(
    parameter int FIFO_width = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int GRANT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_width-1:0] reqData,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifoFull,
    output logic                          fifoWriteEnable,
    output logic [FIFO_width-1:0]         fifoDataIn,
    output logic [GRANT_W-1:0]            grantId,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // Count value held while the final word of a full-length burst is offered
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state;
    logic [GRANT_W-1:0]   last_grant;
    logic [CNT_W-1:0]     burst_cnt;

    logic                 found;
    logic [GRANT_W-1:0]   winner;
    logic [GRANT_W-1:0]   idx;
    logic                 xfer;
    logic                 burst_done;
    logic [FIFO_width-1:0] words [NUM_REQ];

    // Split the flat producer bus into per-producer words
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = reqData[g*FIFO_width +: FIFO_width];
    end

    // Round-robin search: first requester strictly after last_grant, wrapping,
    // so the producer that just finished is considered last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A word moves only in BURST, while enabled, requested and not blocked;
    // reset gates it so the write strobe drops the instant reset asserts.
    assign xfer       = reset && enable && (state == BURST) && req[grantId] && !fifoFull;
    assign burst_done = (xfer && (burst_cnt == LAST_CNT)) || !req[grantId];

    assign fifoWriteEnable = xfer;
    assign ack             = xfer ? (NUM_REQ'(1) << grantId) : '0;
    assign fifoDataIn      = (reset && (state == BURST)) ? words[grantId] : '0;
    assign busy            = (state == BURST);

    // Arbitration / burst FSM; everything freezes while enable is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grantId    <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grantId   <= winner;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (burst_done) begin
                        last_grant <= grantId;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_fifo_write_arbiter
// Brief   : Randomized self-checking bench for fifo_write_arbiter against a
//           transaction-level reference model with a FIFO occupancy queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_write_arbiter;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int MB    = 4;
    localparam int GW    = 2;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  req;
    logic [N*W-1:0] reqData;
    logic [N-1:0]  ack;
    logic          fifoFull;
    logic          fifoWriteEnable;
    logic [W-1:0]  fifoDataIn;
    logic [GW-1:0] grantId;
    logic          busy;

    logic [W-1:0]  pdata [N];

    int checks = 0;
    int errors = 0;

    // Reference model: owner of the current grant (-1 when idle), words taken
    // in this grant, last producer served, registered grant index.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = N - 1;
    int m_gid   = 0;
    logic [W-1:0] fq [$];

    always #5 clk = ~clk;

    always_comb begin
        reqData = '0;
        for (int i = 0; i < N; i++) reqData[i*W +: W] = pdata[i];
    end

    fifo_write_arbiter #(
        .FIFO_width (W),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .req             (req),
        .reqData         (reqData),
        .ack             (ack),
        .fifoFull        (fifoFull),
        .fifoWriteEnable (fifoWriteEnable),
        .fifoDataIn      (fifoDataIn),
        .grantId         (grantId),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_word(input int i);
        logic [7:0] tagb;
        tagb = 8'(i);
        pdata[i] = {tagb, 24'($urandom)};
    endtask

    initial begin
        int  ack_owner;
        logic exp_x;
        logic [N-1:0] exp_ack;

        reset    = 1'b0;
        enable   = 1'b0;
        req      = '0;
        fifoFull = 1'b0;
        for (int i = 0; i < N; i++) pdata[i] = '0;

        // Reset state
        #12;
        check("rst_ack",  64'(ack), 64'(0));
        check("rst_we",   64'(fifoWriteEnable), 64'(0));
        check("rst_data", 64'(fifoDataIn), 64'(0));
        check("rst_gid",  64'(grantId), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        #11 reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_x   = enable && (m_owner >= 0) && req[m_owner] && !fifoFull;
            exp_ack = exp_x ? N'(1 << m_owner) : '0;
            check("ack",  64'(ack), 64'(exp_ack));
            check("we",   64'(fifoWriteEnable), 64'(exp_x));
            check("gid",  64'(grantId), 64'(m_gid));
            check("busy", 64'(busy), 64'(m_owner >= 0));
            if (exp_x) check("data", 64'(fifoDataIn), 64'(pdata[m_owner]));

            @(posedge clk);
            ack_owner = exp_x ? m_owner : -1;
            if (exp_x) fq.push_back(pdata[m_owner]);
            if (enable) begin
                if (m_owner < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_owner < 0 && req[(m_last + k) % N]) begin
                            m_owner = (m_last + k) % N;
                            m_gid   = m_owner;
                            m_cnt   = 0;
                        end
                    end
                end else begin
                    if (exp_x) m_cnt++;
                    if ((exp_x && m_cnt == MB) || !req[m_owner]) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
            end
            if (fq.size() > 0 && $urandom_range(0, 2) == 0) void'(fq.pop_front());

            #1;
            enable = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (i == ack_owner) begin
                    if ($urandom_range(0, 3) != 0) new_word(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    new_word(i);
                end
            end
            fifoFull = (fq.size() >= DEPTH);
        end

        // Asynchronous reset in the middle of a burst from producer 2
        reset    = 1'b0;
        req      = '0;
        enable   = 1'b1;
        fifoFull = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        req = 4'b0100;
        new_word(2);
        @(posedge clk); #1;
        check("mr_gid",   64'(grantId), 64'(2));
        check("mr_busy",  64'(busy), 64'(1));
        check("mr_ack1",  64'(ack), 64'(4'b0100));
        check("mr_data1", 64'(fifoDataIn), 64'(pdata[2]));
        @(posedge clk); #1;
        new_word(2);
        check("mr_ack2",  64'(ack), 64'(4'b0100));
        @(posedge clk); #1;
        new_word(2);
        #2 reset = 1'b0;
        #1;
        check("mr_rst_ack",  64'(ack), 64'(0));
        check("mr_rst_we",   64'(fifoWriteEnable), 64'(0));
        check("mr_rst_gid",  64'(grantId), 64'(0));
        check("mr_rst_busy", 64'(busy), 64'(0));
        #1;
        req = 4'b1100;
        new_word(3);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mr_regrant_gid", 64'(grantId), 64'(2));
        check("mr_regrant_ack", 64'(ack), 64'(4'b0100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
